// File: rtl/prbs_pkg.sv
// Shared definitions for prbs_gen_chk: mode encodings, per-polynomial
// length/tap tables and the checker state encoding.
package prbs_pkg;

    localparam int LFSR_W = 31;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'd0,
        MODE_PRBS15 = 2'd1,
        MODE_PRBS23 = 2'd2,
        MODE_PRBS31 = 2'd3
    } prbs_mode_e;

    // Indexed by mode: feedback = reg[len-1] ^ reg[tap-1]
    localparam int PRBS_LEN [4] = '{7, 15, 23, 31};
    localparam int PRBS_TAP [4] = '{6, 14, 18, 28};

    // Consecutive matches in LOCKED that forgive earlier misses
    localparam int RELOCK_RUN = 16;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_e;

endpackage

// File: rtl/prbs_tap_sel.sv
// Feedback bit of a 31-bit Fibonacci shift register for the selected polynomial.
module prbs_tap_sel
    import prbs_pkg::*;
(
    input  logic [LFSR_W-1:0] sr,
    input  logic [1:0]        mode,
    output logic              fb
);

    logic [3:0] fb_mode;
    logic       unused_sr_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_poly
            assign fb_mode[gi] = sr[PRBS_LEN[gi]-1] ^ sr[PRBS_TAP[gi]-1];
        end
    endgenerate

    assign fb = fb_mode[mode];

    // Only the tap positions matter; the rest of the history is irrelevant here
    assign unused_sr_bits = ^sr;

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS7/15/23/31 generator plus self-synchronising checker with lock FSM.
// Optional macro PRBS_ERR_INJECT_EN adds the inj_err single-bit error injection input.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 32,
    parameter int UNLOCK_N = 8,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
`ifdef PRBS_ERR_INJECT_EN
    input  logic             inj_err,
`endif
    output logic             gen_out,
    input  logic             chk_in,
    input  logic             chk_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int RUN_MAX = (LOCK_CNT > RELOCK_RUN) ? LOCK_CNT : RELOCK_RUN;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int MISS_W  = $clog2(UNLOCK_N + 1);

    localparam logic [RUN_W-1:0]  RUN_LOCK    = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]  RUN_RELOCK  = RUN_W'(RELOCK_RUN);
    localparam logic [MISS_W-1:0] MISS_UNLOCK = MISS_W'(UNLOCK_N);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              gen_out_q, gen_out_d;
    logic [1:0]        mode_prev_q, mode_prev_d;
    logic [LFSR_W-1:0] sr_q, sr_d;
    chk_state_e        state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic              gen_fb;
    logic              gen_bit;
    logic              chk_fb;
    logic              mode_change;
    logic              mismatch;
    logic [RUN_W-1:0]  run_inc;
    logic [MISS_W-1:0] miss_inc;

    prbs_tap_sel u_gen_tap (
        .sr   (lfsr_q),
        .mode (mode),
        .fb   (gen_fb)
    );

    prbs_tap_sel u_chk_tap (
        .sr   (sr_q),
        .mode (mode),
        .fb   (chk_fb)
    );

`ifdef PRBS_ERR_INJECT_EN
    // Only the emitted bit is corrupted; the LFSR keeps the true feedback
    assign gen_bit = gen_fb ^ inj_err;
`else
    assign gen_bit = gen_fb;
`endif

    assign mode_change = (mode != mode_prev_q);
    assign mismatch    = chk_in ^ chk_fb;
    assign run_inc     = run_q + RUN_W'(1);
    assign miss_inc    = miss_q + MISS_W'(1);

    always_comb begin
        lfsr_d      = lfsr_q;
        gen_out_d   = gen_out_q;
        mode_prev_d = mode;
        if (mode_change) begin
            lfsr_d = '1;
        end else if (en) begin
            lfsr_d    = {lfsr_q[LFSR_W-2:0], gen_fb};
            gen_out_d = gen_bit;
        end
    end

    always_comb begin
        sr_d        = sr_q;
        state_d     = state_q;
        run_d       = run_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        // The checker history tracks the received stream in every state
        if (chk_valid) begin
            sr_d = {sr_q[LFSR_W-2:0], chk_in};
        end

        if (mode_change) begin
            state_d = ST_SEARCH;
            run_d   = '0;
            miss_d  = '0;
        end else if (chk_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (mismatch) begin
                        run_d = '0;
                    end else if (run_inc == RUN_LOCK) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                        miss_d  = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                ST_LOCKED: begin
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        run_d = '0;
                        if (miss_inc == MISS_UNLOCK) begin
                            state_d = ST_SEARCH;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else if (run_inc == RUN_RELOCK) begin
                        run_d  = '0;
                        miss_d = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        if (err_clr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q      <= '1;
            gen_out_q   <= 1'b0;
            mode_prev_q <= mode;
            sr_q        <= '0;
            state_q     <= ST_SEARCH;
            run_q       <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            gen_out_q   <= gen_out_d;
            mode_prev_q <= mode_prev_d;
            sr_q        <= sr_d;
            state_q     <= state_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign gen_out   = gen_out_q;
    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: generator sequence, loopback lock, error
// counting, mode switching, saturation (ERR_W=4 instance) and optional injection.
module tb_prbs_gen_chk;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic        chk_in;
    logic        chk_valid;
    logic        err_clr;
    logic        flip;
    logic        force_zero;
`ifdef PRBS_ERR_INJECT_EN
    logic        inj_err;
`endif

    logic        gen_out, locked, err_pulse;
    logic [15:0] err_cnt;
    logic        gen_out_w4, locked_w4, err_pulse_w4;
    logic [3:0]  err_cnt_w4;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    always #5 clk = ~clk;

    assign chk_in = force_zero ? 1'b0 : (gen_out ^ flip);

    prbs_gen_chk dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
`ifdef PRBS_ERR_INJECT_EN
        .inj_err   (inj_err),
`endif
        .gen_out   (gen_out),
        .chk_in    (chk_in),
        .chk_valid (chk_valid),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    prbs_gen_chk #(.ERR_W(4)) dut_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
`ifdef PRBS_ERR_INJECT_EN
        .inj_err   (inj_err),
`endif
        .gen_out   (gen_out_w4),
        .chk_in    (chk_in),
        .chk_valid (chk_valid),
        .err_clr   (err_clr),
        .locked    (locked_w4),
        .err_pulse (err_pulse_w4),
        .err_cnt   (err_cnt_w4)
    );

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end else begin
            $display("vec %0d %s: got %0h ok", vec_cnt, tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        bits [0:299];
    logic [15:0] first16;
    int          ones, per_err, lock_edge, pulses, base, inj_idx, n;

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; chk_valid = 1'b0;
        err_clr = 1'b0; flip = 1'b0; force_zero = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
        inj_err = 1'b0;
`endif
        repeat (3) tick();
        check_vec("rst_gen_out", gen_out, 0);
        check_vec("rst_locked", locked, 0);
        check_vec("rst_err_pulse", err_pulse, 0);
        check_vec("rst_err_cnt", err_cnt, 0);

        // PRBS7 free run: sequence from the all-ones seed is 0000001 0000011 00...
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 254; i++) begin
            tick();
            bits[i] = gen_out;
        end
        first16 = '0;
        for (int i = 0; i < 16; i++) first16 = {first16[14:0], bits[i]};
        ones = 0;
        per_err = 0;
        for (int i = 0; i < 127; i++) begin
            ones += int'(bits[i]);
            if (bits[i] !== bits[i+127]) per_err++;
        end
        check_vec("prbs7_first16", first16, 32'h020C);
        check_vec("prbs7_ones", ones, 64);
        check_vec("prbs7_period", per_err, 0);
        en = 1'b0;
        repeat (3) tick();
        check_vec("en_low_hold", gen_out, 1);
        en = 1'b1;
        tick();
        check_vec("en_resume", gen_out, 0);

        // PRBS31 loopback from reset: lock after bit 62 is sampled
        rst_n = 1'b0; mode = 2'd3; en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1; en = 1'b1;
        tick();
        chk_valid = 1'b1;
        lock_edge = 0;
        for (int e = 1; e <= 70; e++) begin
            tick();
            if (locked && lock_edge == 0) lock_edge = e;
        end
        check_vec("p31_lock_edge", lock_edge, 63);
        repeat (10000) tick();
        check_vec("p31_long_err_cnt", err_cnt, 0);
        check_vec("p31_long_locked", locked, 1);

        // Constant-zero input while locked: 8 counted misses drop lock
        force_zero = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (err_pulse) pulses++;
            if (!locked) break;
        end
        check_vec("force0_locked", locked, 0);
        check_vec("force0_pulses", pulses, 8);
        check_vec("force0_err_cnt", err_cnt, 8);
        pulses = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (err_pulse) pulses++;
        end
        check_vec("search_no_pulse", pulses, 0);
        check_vec("search_err_cnt", err_cnt, 8);

        force_zero = 1'b0;
        lock_edge = 0;
        for (int e = 1; e <= 80; e++) begin
            tick();
            if (locked && lock_edge == 0) lock_edge = e;
        end
        check_vec("p31_relock_bound", (lock_edge >= 32 && lock_edge <= 63), 1);

        // Mode 3 -> 1: immediate unlock, reseed, relock within 48 edges
        mode = 2'd1;
        tick();
        check_vec("mode_chg_unlock", locked, 0);
        check_vec("mode_chg_err_cnt", err_cnt, 8);
        first16 = '0;
        lock_edge = 0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (e <= 16) first16 = {first16[14:0], gen_out};
            if (locked && lock_edge == 0) lock_edge = e;
        end
        check_vec("prbs15_first16", first16, 32'h0002);
        check_vec("p15_relock_bound", (lock_edge >= 32 && lock_edge <= 48), 1);

        // Mode 1 -> 0 and PRBS7 relock
        mode = 2'd0;
        tick();
        lock_edge = 0;
        for (int e = 1; e <= 50; e++) begin
            tick();
            if (locked && lock_edge == 0) lock_edge = e;
        end
        check_vec("p7_relock_bound", (lock_edge >= 32 && lock_edge <= 40), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_vec("err_clr_cnt", err_cnt, 0);
        check_vec("err_clr_cnt_w4", err_cnt_w4, 0);
        repeat (5) tick();

        // Single flipped bit: pulses on the bit itself and 6 and 7 bits later
        flip = 1'b1;
        tick();
        flip = 1'b0;
        check_vec("flip_pulse0", err_pulse, 1);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (err_pulse) pulses |= (1 << (k - 1));
        end
        check_vec("flip_pulse_pat", pulses, 32'h60);
        check_vec("flip_err_cnt", err_cnt, 3);
        check_vec("flip_locked", locked, 1);

        repeat (30) tick();
        flip = 1'b1; err_clr = 1'b1;
        tick();
        flip = 1'b0; err_clr = 1'b0;
        check_vec("clr_wins_cnt", err_cnt, 0);
        check_vec("clr_wins_pulse", err_pulse, 1);
        repeat (10) tick();
        check_vec("clr_wins_after", err_cnt, 2);

        // Six more flips, spaced so the miss counter is forgiven in between
        for (int f = 0; f < 6; f++) begin
            repeat (30) tick();
            flip = 1'b1;
            tick();
            flip = 1'b0;
        end
        repeat (30) tick();
        check_vec("multi_err_cnt", err_cnt, 20);
        check_vec("sat_err_cnt_w4", err_cnt_w4, 15);
        check_vec("multi_locked", locked, 1);

        // chk_valid and en low: nothing moves, garbage on chk_in ignored
        en = 1'b0; chk_valid = 1'b0; flip = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (err_pulse) pulses++;
        end
        flip = 1'b0; en = 1'b1; chk_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (err_pulse) pulses++;
        end
        check_vec("freeze_pulses", pulses, 0);
        check_vec("freeze_err_cnt", err_cnt, 20);
        check_vec("freeze_locked", locked, 1);

`ifdef PRBS_ERR_INJECT_EN
        n = 0;
        for (int k = 0; k < 130; k++) begin
            tick();
            bits[n] = gen_out;
            n++;
        end
        inj_err = 1'b1;
        tick();
        inj_err = 1'b0;
        bits[n] = gen_out;
        inj_idx = n;
        n++;
        for (int k = 0; k < 40; k++) begin
            tick();
            bits[n] = gen_out;
            n++;
        end
        check_vec("inj_bit_inverted", bits[inj_idx], ~bits[inj_idx-127]);
        per_err = 0;
        for (int i = inj_idx + 1; i < n; i++) begin
            if (bits[i] !== bits[i-127]) per_err++;
        end
        check_vec("inj_seq_unchanged", per_err, 0);
        check_vec("inj_err_cnt", err_cnt, 23);
        check_vec("inj_locked", locked, 1);
`endif

        // Reset in mid-run with every other input active
        rst_n = 1'b0; err_clr = 1'b0;
        tick();
        check_vec("midrst_gen_out", gen_out, 0);
        check_vec("midrst_locked", locked, 0);
        check_vec("midrst_err_pulse", err_pulse, 0);
        check_vec("midrst_err_cnt", err_cnt, 0);
        check_vec("midrst_err_cnt_w4", err_cnt_w4, 0);
        rst_n = 1'b1;
        base = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            base = (base << 1) | int'(gen_out);
        end
        check_vec("midrst_prbs7_first7", base, 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 32: consecutive matching bits needed to declare lock.
REQ-002 SHALL have parameter UNLOCK_N, default 8: mismatch count that drops lock.
REQ-003 SHALL have parameter ERR_W, default 16: error counter width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  input  1  generator advance enable.
REQ-007 SHALL have port mode  input  2  polynomial select: 0 PRBS7 x^7+x^6+1, 1 PRBS15 x^15+x^14+1, 2 PRBS23 x^23+x^18+1, 3 PRBS31 x^31+x^28+1.
REQ-008 SHALL have port gen_out  output  1  registered generated bit.
REQ-009 SHALL have port chk_in  input  1  received bit; chk_valid  input  1  qualifies chk_in.
REQ-010 SHALL have port err_clr  input  1  clears err_cnt.
REQ-011 SHALL have outputs locked (1, checker in LOCKED), err_pulse (1, one-cycle mismatch flag), err_cnt (ERR_W, saturating error count).

Function
REQ-012 Generator SHALL be a 31-bit Fibonacci LFSR; active length n and tap t per mode; feedback = lfsr[n-1] XOR lfsr[t-1]; on en, shift left, lfsr[0] <= feedback, gen_out <= feedback.
REQ-013 With en low, LFSR and gen_out SHALL hold.
REQ-014 Mode change (mode differs from registered previous mode) SHALL reseed LFSR to all-ones the next cycle, force checker to SEARCH and clear its match/miss counters; err_cnt unaffected.
REQ-015 Checker SHALL be self-synchronising: on chk_valid, predicted = sr[n-1] XOR sr[t-1]; mismatch = chk_in != predicted; then sr shifts in chk_in (in both states).
REQ-016 Checker FSM SHALL have states SEARCH and LOCKED; reset state SEARCH.
REQ-017 SEARCH: match increments run counter, mismatch clears it; run counter reaching LOCK_CNT SHALL enter LOCKED, locked high the following cycle.
REQ-018 LOCKED: each mismatch SHALL raise err_pulse for exactly one cycle (cycle after the sampled bit) and increment err_cnt, saturating at all-ones.
REQ-019 LOCKED: mismatches SHALL increment a miss counter, cleared by 16 consecutive matches; miss counter reaching UNLOCK_N SHALL return to SEARCH with locked low next cycle.
REQ-020 Mismatches in SEARCH SHALL NOT touch err_cnt or err_pulse.
REQ-021 err_clr SHALL zero err_cnt next cycle; err_clr coincident with a counted mismatch SHALL yield 0 (clear wins).
REQ-022 chk_valid low SHALL freeze sr, counters and FSM; err_pulse low.

Reset
REQ-023 rst_n low at a clock edge SHALL set LFSR all-ones, sr zero, gen_out 0, locked 0, err_pulse 0, err_cnt 0, FSM SEARCH, run/miss counters 0, previous-mode register to current mode; applies mid-sequence and overrides all other inputs.

Configuration
REQ-024 With PRBS_ERR_INJECT_EN defined, SHALL add input inj_err (1): when inj_err and en high, gen_out is the inverted feedback bit for that cycle only; LFSR state keeps the true bit.
REQ-025 Without PRBS_ERR_INJECT_EN, inj_err port and logic SHALL be absent; gen_out always the true feedback bit.

Structure
REQ-026 Package prbs_pkg SHALL hold mode encodings, per-mode length/tap constant tables and checker state enum.
REQ-027 Sub-module prbs_tap_sel SHALL compute feedback from a 31-bit register and mode; instanced once for generator, once for checker.

Verification
REQ-028 Reset then mode=0, en=1 for 127 cycles -> gen_out period 127, first bit 0, exactly 64 ones per period.
REQ-029 Loopback gen_out->chk_in, chk_valid=en=1, mode=3, defaults -> locked high within 31+32+1 cycles of first valid; err_cnt 0 after 10000 cycles.
REQ-030 Locked PRBS7 loopback, single chk_in bit flipped -> three err_pulse cycles, err_cnt=3, locked stays high.
REQ-031 Locked, chk_in forced constant 0 -> err_cnt grows, locked falls after 8 counted mismatches; err_clr with concurrent mismatch -> err_cnt 0.
REQ-032 Locked, mode 3->1 -> locked low next cycle, LFSR all-ones, relock within 15+32+1 cycles; ERR_W=4 with errors forced -> err_cnt holds 15.
REQ-033 With PRBS_ERR_INJECT_EN, locked loopback mode=0, one inj_err pulse -> err_cnt=3, subsequent gen_out sequence unchanged versus reference model.
